// File: rtl/gt2_sop_if.sv
// Operand/result bundle for the 2-bit SOP magnitude comparator.
// The master drives operands; the slave (comparator) returns the flags.
interface gt2_sop_if;
  logic [1:0] a;
  logic [1:0] b;
  logic       in_valid;
  logic       agtb;
  logic       out_valid;
  logic       agtb_r;
  logic       aeqb_r;
  logic       altb_r;

  modport master (
    output a, b, in_valid,
    input  agtb, out_valid, agtb_r, aeqb_r, altb_r
  );

  modport slave (
    input  a, b, in_valid,
    output agtb, out_valid, agtb_r, aeqb_r, altb_r
  );
endinterface

// File: rtl/gt2_sop.sv
// 2-bit unsigned magnitude comparator in hand-derived sum-of-products form.
// agtb is combinational; gt/eq/lt flags are captured when in_valid is high.
module gt2_sop (
  input  logic       clk,
  input  logic       rst_n,
  gt2_sop_if.slave   bus
);

  logic [1:0] bit_eq;
  logic       gt;
  logic       eq;
  logic       lt;

  logic       out_valid_q, out_valid_d;
  logic       agtb_q,      agtb_d;
  logic       aeqb_q,      aeqb_d;
  logic       altb_q,      altb_d;

  // Per-bit equality terms feed the eq product.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_bit_eq
      assign bit_eq[gi] = ~(bus.a[gi] ^ bus.b[gi]);
    end
  endgenerate

  assign gt = (bus.a[1] & ~bus.b[1])
            | (bus.a[1] & bus.a[0] & ~bus.b[0])
            | (bus.a[0] & ~bus.b[1] & ~bus.b[0]);
  assign eq = bit_eq[1] & bit_eq[0];
  assign lt = ~gt & ~eq;

  always_comb begin
    out_valid_d = bus.in_valid;
    agtb_d      = agtb_q;
    aeqb_d      = aeqb_q;
    altb_d      = altb_q;
    if (bus.in_valid) begin
      agtb_d = gt;
      aeqb_d = eq;
      altb_d = lt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      agtb_q      <= 1'b0;
      aeqb_q      <= 1'b0;
      altb_q      <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      agtb_q      <= agtb_d;
      aeqb_q      <= aeqb_d;
      altb_q      <= altb_d;
    end
  end

  assign bus.agtb      = gt;
  assign bus.out_valid = out_valid_q;
  assign bus.agtb_r    = agtb_q;
  assign bus.aeqb_r    = aeqb_q;
  assign bus.altb_r    = altb_q;

endmodule

// File: tb/tb_gt2_sop.sv
// Directed and randomized checks of the 2-bit SOP comparator: combinational
// output, capture/hold behaviour, reset priority and one-hot flags.
module tb_gt2_sop;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  gt2_sop_if bus ();

  gt2_sop dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and return to the falling edge for sampling.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; bus.in_valid = 1'b1; bus.a = 2'b11; bus.b = 2'b00;
    step();
    $display("txn reset a=%b b=%b in_valid=1", bus.a, bus.b);
    checks++;
    if ({bus.out_valid, bus.agtb_r, bus.aeqb_r, bus.altb_r} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_regs: got %b expected 0000",
               {bus.out_valid, bus.agtb_r, bus.aeqb_r, bus.altb_r});
    end
    #1;
    checks++;
    if (bus.agtb !== 1'b1) begin
      errors++;
      $display("FAIL reset_agtb_comb: got %b expected 1", bus.agtb);
    end
    rst_n = 1'b1; bus.in_valid = 1'b0;
    step();
  endtask

  task automatic test_comb_sweep();
    // Hand-listed truth column for a>b, indexed by {a,b}.
    logic [15:0] gt_table;
    gt_table = 16'b0111_0011_0001_0000;
    bus.in_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      bus.a = i[3:2]; bus.b = i[1:0];
      #1;
      $display("txn comb a=%b b=%b agtb=%b", bus.a, bus.b, bus.agtb);
      checks++;
      if (bus.agtb !== gt_table[i]) begin
        errors++;
        $display("FAIL comb_sweep a=%b b=%b: got %b expected %b",
                 bus.a, bus.b, bus.agtb, gt_table[i]);
      end
      #199;
    end
    @(negedge clk);
  endtask

  task automatic test_equality();
    for (int v = 0; v < 4; v++) begin
      bus.in_valid = 1'b1; bus.a = v[1:0]; bus.b = v[1:0];
      #1;
      checks++;
      if (bus.agtb !== 1'b0) begin
        errors++;
        $display("FAIL eq_diag_comb v=%0d: got %b expected 0", v, bus.agtb);
      end
      step();
      $display("txn eq a=b=%b flags=%b%b%b", v[1:0], bus.agtb_r, bus.aeqb_r, bus.altb_r);
      checks++;
      if ({bus.agtb_r, bus.aeqb_r, bus.altb_r, bus.out_valid} !== 4'b0101) begin
        errors++;
        $display("FAIL eq_diag_reg v=%0d: got %b expected 0101", v,
                 {bus.agtb_r, bus.aeqb_r, bus.altb_r, bus.out_valid});
      end
    end
    bus.in_valid = 1'b0;
    step();
  endtask

  task automatic test_registered();
    bus.in_valid = 1'b1; bus.a = 2'b10; bus.b = 2'b01;
    step();
    bus.in_valid = 1'b0;
    $display("txn reg a=10 b=01 flags=%b%b%b ov=%b",
             bus.agtb_r, bus.aeqb_r, bus.altb_r, bus.out_valid);
    checks++;
    if ({bus.agtb_r, bus.aeqb_r, bus.altb_r, bus.out_valid} !== 4'b1001) begin
      errors++;
      $display("FAIL registered_path: got %b expected 1001",
               {bus.agtb_r, bus.aeqb_r, bus.altb_r, bus.out_valid});
    end
    step();
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL out_valid_pulse: got %b expected 0", bus.out_valid);
    end
  endtask

  task automatic test_hold();
    bus.in_valid = 1'b1; bus.a = 2'b00; bus.b = 2'b11;
    step();
    checks++;
    if ({bus.agtb_r, bus.aeqb_r, bus.altb_r} !== 3'b001) begin
      errors++;
      $display("FAIL hold_capture: got %b expected 001",
               {bus.agtb_r, bus.aeqb_r, bus.altb_r});
    end
    bus.in_valid = 1'b0; bus.a = 2'b11; bus.b = 2'b00;
    step();
    $display("txn hold a=11 b=00 in_valid=0 flags=%b%b%b",
             bus.agtb_r, bus.aeqb_r, bus.altb_r);
    checks++;
    if ({bus.agtb_r, bus.aeqb_r, bus.altb_r, bus.out_valid} !== 4'b0010) begin
      errors++;
      $display("FAIL hold_keep: got %b expected 0010",
               {bus.agtb_r, bus.aeqb_r, bus.altb_r, bus.out_valid});
    end
    checks++;
    if (bus.agtb !== 1'b1) begin
      errors++;
      $display("FAIL hold_agtb_comb: got %b expected 1", bus.agtb);
    end
  endtask

  task automatic test_reset_midstream();
    bus.in_valid = 1'b1; bus.a = 2'b11; bus.b = 2'b00;
    step();
    checks++;
    if (bus.agtb_r !== 1'b1) begin
      errors++;
      $display("FAIL midreset_pre: got %b expected 1", bus.agtb_r);
    end
    rst_n = 1'b0;
    step();
    $display("txn midstream reset flags=%b%b%b ov=%b",
             bus.agtb_r, bus.aeqb_r, bus.altb_r, bus.out_valid);
    checks++;
    if ({bus.agtb_r, bus.aeqb_r, bus.altb_r, bus.out_valid} !== 4'b0000) begin
      errors++;
      $display("FAIL midreset_clear: got %b expected 0000",
               {bus.agtb_r, bus.aeqb_r, bus.altb_r, bus.out_valid});
    end
    rst_n = 1'b1; bus.in_valid = 1'b0;
    step();
  endtask

  task automatic test_back_to_back();
    // {a, b, expected gt/eq/lt}
    logic [6:0] vec [6];
    vec[0] = {2'b11, 2'b00, 3'b100};
    vec[1] = {2'b00, 2'b11, 3'b001};
    vec[2] = {2'b11, 2'b11, 3'b010};
    vec[3] = {2'b01, 2'b10, 3'b001};
    vec[4] = {2'b11, 2'b10, 3'b100};
    vec[5] = {2'b00, 2'b00, 3'b010};
    for (int i = 0; i < 6; i++) begin
      bus.in_valid = 1'b1; bus.a = vec[i][6:5]; bus.b = vec[i][4:3];
      step();
      $display("txn b2b a=%b b=%b flags=%b%b%b", vec[i][6:5], vec[i][4:3],
               bus.agtb_r, bus.aeqb_r, bus.altb_r);
      checks++;
      if ({bus.agtb_r, bus.aeqb_r, bus.altb_r, bus.out_valid} !== {vec[i][2:0], 1'b1}) begin
        errors++;
        $display("FAIL back_to_back[%0d]: got %b expected %b", i,
                 {bus.agtb_r, bus.aeqb_r, bus.altb_r, bus.out_valid}, {vec[i][2:0], 1'b1});
      end
    end
    bus.in_valid = 1'b0;
    step();
  endtask

  task automatic test_onehot_random();
    logic [2:0] exp_flags;
    logic       exp_ov;
    int         fails_before;
    fails_before = errors;
    exp_flags = {bus.agtb_r, bus.aeqb_r, bus.altb_r};
    for (int i = 0; i < 1000; i++) begin
      bus.a = 2'($urandom_range(0, 3));
      bus.b = 2'($urandom_range(0, 3));
      bus.in_valid = 1'($urandom_range(0, 1));
      exp_ov = bus.in_valid;
      if (bus.in_valid)
        exp_flags = {bus.a > bus.b, bus.a == bus.b, bus.a < bus.b};
      step();
      checks++;
      if ({bus.agtb_r, bus.aeqb_r, bus.altb_r, bus.out_valid} !== {exp_flags, exp_ov}) begin
        errors++;
        $display("FAIL random_model[%0d]: got %b expected %b", i,
                 {bus.agtb_r, bus.aeqb_r, bus.altb_r, bus.out_valid}, {exp_flags, exp_ov});
      end
      if (bus.out_valid === 1'b1) begin
        checks++;
        if ((32'(bus.agtb_r) + 32'(bus.aeqb_r) + 32'(bus.altb_r)) != 1) begin
          errors++;
          $display("FAIL onehot[%0d]: got %b expected exactly one set", i,
                   {bus.agtb_r, bus.aeqb_r, bus.altb_r});
        end
      end
    end
    $display("txn random 1000 cycles, new errors %0d", errors - fails_before);
    bus.in_valid = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bus.a = 2'b00; bus.b = 2'b00; bus.in_valid = 1'b0;
    @(negedge clk);
    test_reset();
    test_comb_sweep();
    test_equality();
    test_registered();
    test_hold();
    test_reset_midstream();
    test_back_to_back();
    test_onehot_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
